csr_bus_master: RTL and testbench



---
 rtl/csr_bus_master_if.sv | 36 +++
 rtl/csr_bus_master.sv | 207 ++++++++++++++++++++
 tb/tb_csr_bus_master.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_bus_master_if.sv
// Port bundle for csr_bus_master: command/response handshakes plus the CSR bus.
// master = the bus master's view, slave = the sequencer/CSR-map side.
interface csr_bus_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic [DATA_W-1:0] cmd_mask_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;
    logic [ADDR_W-1:0] reg_addr_o;
    logic [DATA_W-1:0] reg_wr_data_o;
    logic              reg_wr_en_o;
    logic              reg_rd_en_o;
    logic [DATA_W-1:0] reg_rd_data_i;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
        input  rsp_ready_i, reg_rd_data_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output reg_addr_o, reg_wr_data_o, reg_wr_en_o, reg_rd_en_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_mask_i,
        output rsp_ready_i, reg_rd_data_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  reg_addr_o, reg_wr_data_o, reg_wr_en_o, reg_rd_en_o
    );
endinterface

// File: rtl/csr_bus_master.sv
// CSR bus initiator: WRITE / READ / RMW / POLL commands, one strobe per access.
// Define CSR_BUS_MASTER_POLL_EN to enable POLL; otherwise op 3 returns an error.
module csr_bus_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1,
    parameter int POLL_MAX   = 16,
    parameter int POLL_GAP   = 4
) (
    input  logic             reg_clk_i,
    input  logic             reg_rst_n_i,
    csr_bus_master_if.master bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR      = 3'd1;
    localparam logic [2:0] ST_RD      = 3'd2;
    localparam logic [2:0] ST_RD_WAIT = 3'd3;
    localparam logic [2:0] ST_RMW_WR  = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;
`ifdef CSR_BUS_MASTER_POLL_EN
    localparam logic [2:0] ST_GAP     = 3'd6;
`endif

    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_RMW   = 2'd2;
    localparam logic [1:0] OP_POLL  = 2'd3;

    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
        $error("RD_LATENCY must be 1..4");
    end
    if (POLL_MAX < 1 || POLL_MAX > 255) begin : g_bad_pmax
        $error("POLL_MAX must be 1..255");
    end
    if (POLL_GAP < 0 || POLL_GAP > 15) begin : g_bad_pgap
        $error("POLL_GAP must be 0..15");
    end

    logic [2:0]        state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mask_q;
    logic [2:0]        lat_cnt;
    logic [DATA_W-1:0] merged;
`ifdef CSR_BUS_MASTER_POLL_EN
    logic [7:0]        poll_cnt;
    logic [3:0]        gap_cnt;
    logic              poll_match;
    logic              poll_last;
`endif

    always_comb begin
        merged = (bus.reg_rd_data_i & ~mask_q) | (data_q & mask_q);
    end

`ifdef CSR_BUS_MASTER_POLL_EN
    always_comb begin
        poll_match = ((bus.reg_rd_data_i ^ data_q) & mask_q) == '0;
        // Read just sampled is the POLL_MAX-th one: no further strobe allowed.
        poll_last  = ({1'b0, poll_cnt} + 9'd1) >= 9'(POLL_MAX);
    end
`endif

    always_ff @(posedge reg_clk_i or negedge reg_rst_n_i) begin
        if (!reg_rst_n_i) begin
            state             <= ST_IDLE;
            op_q              <= OP_WRITE;
            data_q            <= '0;
            mask_q            <= '0;
            lat_cnt           <= '0;
`ifdef CSR_BUS_MASTER_POLL_EN
            poll_cnt          <= '0;
            gap_cnt           <= '0;
`endif
            bus.cmd_ready_o   <= 1'b1;
            bus.rsp_valid_o   <= 1'b0;
            bus.rsp_data_o    <= '0;
            bus.rsp_err_o     <= 1'b0;
            bus.reg_addr_o    <= '0;
            bus.reg_wr_data_o <= '0;
            bus.reg_wr_en_o   <= 1'b0;
            bus.reg_rd_en_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        bus.cmd_ready_o   <= 1'b0;
                        op_q              <= bus.cmd_op_i;
                        data_q            <= bus.cmd_data_i;
                        mask_q            <= bus.cmd_mask_i;
                        bus.reg_addr_o    <= bus.cmd_addr_i;
                        bus.reg_wr_data_o <= bus.cmd_data_i;
                        lat_cnt           <= '0;
`ifdef CSR_BUS_MASTER_POLL_EN
                        poll_cnt          <= '0;
                        gap_cnt           <= '0;
`endif
                        case (bus.cmd_op_i)
                            OP_WRITE: begin
                                bus.reg_wr_en_o <= 1'b1;
                                state           <= ST_WR;
                            end
                            OP_READ, OP_RMW: begin
                                bus.reg_rd_en_o <= 1'b1;
                                state           <= ST_RD;
                            end
                            OP_POLL: begin
`ifdef CSR_BUS_MASTER_POLL_EN
                                bus.reg_rd_en_o <= 1'b1;
                                state           <= ST_RD;
`else
                                bus.rsp_valid_o <= 1'b1;
                                bus.rsp_data_o  <= '0;
                                bus.rsp_err_o   <= 1'b1;
                                state           <= ST_RESP;
`endif
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    bus.reg_wr_en_o <= 1'b0;
                    bus.rsp_valid_o <= 1'b1;
                    bus.rsp_data_o  <= data_q;
                    bus.rsp_err_o   <= 1'b0;
                    state           <= ST_RESP;
                end
                ST_RD: begin
                    bus.reg_rd_en_o <= 1'b0;
                    lat_cnt         <= '0;
                    state           <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    if (lat_cnt != LAT_LAST) begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end else begin
                        case (op_q)
                            OP_RMW: begin
                                bus.reg_wr_data_o <= merged;
                                bus.reg_wr_en_o   <= 1'b1;
                                state             <= ST_RMW_WR;
                            end
`ifdef CSR_BUS_MASTER_POLL_EN
                            OP_POLL: begin
                                if (poll_match || poll_last) begin
                                    bus.rsp_valid_o <= 1'b1;
                                    bus.rsp_data_o  <= bus.reg_rd_data_i;
                                    bus.rsp_err_o   <= !poll_match;
                                    state           <= ST_RESP;
                                end else begin
                                    poll_cnt <= (poll_cnt == 8'hFF) ? poll_cnt : poll_cnt + 8'd1;
                                    gap_cnt  <= '0;
                                    if (POLL_GAP == 0) begin
                                        bus.reg_rd_en_o <= 1'b1;
                                        state           <= ST_RD;
                                    end else begin
                                        state <= ST_GAP;
                                    end
                                end
                            end
`endif
                            default: begin
                                bus.rsp_valid_o <= 1'b1;
                                bus.rsp_data_o  <= bus.reg_rd_data_i;
                                bus.rsp_err_o   <= 1'b0;
                                state           <= ST_RESP;
                            end
                        endcase
                    end
                end
`ifdef CSR_BUS_MASTER_POLL_EN
                ST_GAP: begin
                    if (gap_cnt == 4'(POLL_GAP - 1)) begin
                        bus.reg_rd_en_o <= 1'b1;
                        state           <= ST_RD;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
`endif
                ST_RMW_WR: begin
                    bus.reg_wr_en_o <= 1'b0;
                    bus.rsp_valid_o <= 1'b1;
                    bus.rsp_data_o  <= bus.reg_wr_data_o;
                    bus.rsp_err_o   <= 1'b0;
                    state           <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready_i) begin
                        bus.rsp_valid_o <= 1'b0;
                        bus.cmd_ready_o <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    bus.reg_wr_en_o <= 1'b0;
                    bus.reg_rd_en_o <= 1'b0;
                    bus.rsp_valid_o <= 1'b0;
                    bus.cmd_ready_o <= 1'b1;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csr_bus_master.sv
// Bench for csr_bus_master: responder memory, per-cycle expectation tables
// filled from the command semantics, and literal pins on key results.
module tb_csr_bus_master;
    localparam int AW = 8, DW = 32, L = 1, PMAX = 3, PGAP = 2, NC = 4096;
    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_RMW = 2'd2, OP_POLL = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    csr_bus_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    csr_bus_master #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L), .POLL_MAX(PMAX), .POLL_GAP(PGAP)
    ) dut (
        .reg_clk_i   (clk),
        .reg_rst_n_i (rst_n),
        .bus         (bus)
    );

    // Responder: one-cycle read latency CSR space, plus a bench-side write port.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] ref_mem [256];
    logic          bench_we = 1'b0;
    logic [AW-1:0] bench_addr = '0;
    logic [DW-1:0] bench_data = '0;

    always @(posedge clk) begin
        if (bench_we) mem[bench_addr] <= bench_data;
        if (bus.reg_wr_en_o) mem[bus.reg_addr_o] <= bus.reg_wr_data_o;
        if (bus.reg_rd_en_o) bus.reg_rd_data_i <= mem[bus.reg_addr_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit            exp_rd [NC];
    bit            exp_wr [NC];
    bit            exp_rv [NC];
    bit            exp_cr [NC];
    bit            exp_av [NC];
    bit            exp_err [NC];
    logic [AW-1:0] exp_addr [NC];
    logic [DW-1:0] exp_wd [NC];
    logic [DW-1:0] exp_rdat [NC];

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    int            rd_seen = 0, wr_seen = 0, rsp_first = 0;
    logic          prev_rv = 1'b0;
    logic [DW-1:0] last_data = '0;
    logic          last_err = 1'b0;

    always @(negedge clk) begin
        if (chk_en && cyc < NC) begin
            check("rd_en", bus.reg_rd_en_o, exp_rd[cyc]);
            check("wr_en", bus.reg_wr_en_o, exp_wr[cyc]);
            check("cmd_ready", bus.cmd_ready_o, exp_cr[cyc]);
            check("rsp_valid", bus.rsp_valid_o, exp_rv[cyc]);
            if (exp_rv[cyc]) begin
                check("rsp_data", bus.rsp_data_o, exp_rdat[cyc]);
                check("rsp_err", bus.rsp_err_o, exp_err[cyc]);
            end
            if (exp_av[cyc]) check("reg_addr", bus.reg_addr_o, exp_addr[cyc]);
            if (exp_wr[cyc]) check("wr_data", bus.reg_wr_data_o, exp_wd[cyc]);
        end
        if (bus.reg_rd_en_o) rd_seen <= rd_seen + 1;
        if (bus.reg_wr_en_o) wr_seen <= wr_seen + 1;
        if (bus.rsp_valid_o && !prev_rv) rsp_first <= cyc;
        if (bus.rsp_valid_o && bus.rsp_ready_i) begin
            last_data <= bus.rsp_data_o;
            last_err  <= bus.rsp_err_o;
        end
        prev_rv <= bus.rsp_valid_o;
    end

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(posedge clk); #1;
        bench_we = 1'b1; bench_addr = a; bench_data = v;
        ref_mem[a] = v;
        @(posedge clk); #1;
        bench_we = 1'b0;
    endtask

    // Issue one command and record what the bus must show, cycle by cycle.
    // ks/va: for POLL, the responder value changes to va before read number ks.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] m,
                         input int stall, input int ks, input logic [DW-1:0] va,
                         output int t_acc);
        int T, R, sw;
        logic [DW-1:0] v, n, rdat;
        logic err;
        @(posedge clk); #1;
        T = cyc; sw = -1; err = 1'b0; rdat = '0; R = T + 1;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = op; bus.cmd_addr_i = a;
        bus.cmd_data_i = d; bus.cmd_mask_i = m;
        bus.rsp_ready_i = (stall == 0);
        bench_addr = a; bench_data = va;
        case (op)
            OP_WR: begin
                exp_wr[T+1] = 1'b1; exp_wd[T+1] = d;
                rdat = d; ref_mem[a] = d; R = T + 2;
            end
            OP_RD: begin
                exp_rd[T+1] = 1'b1; rdat = ref_mem[a]; R = T + 2 + L;
            end
            OP_RMW: begin
                exp_rd[T+1] = 1'b1;
                v = ref_mem[a];
                n = (v & ~m) | (d & m);
                exp_wr[T+2+L] = 1'b1; exp_wd[T+2+L] = n;
                rdat = n; ref_mem[a] = n; R = T + 3 + L;
            end
            default: begin
`ifdef CSR_BUS_MASTER_POLL_EN
                int nrd, S;
                S = 1 + L + PGAP;
                nrd = 0;
                for (int k = 0; k < PMAX; k++) begin
                    v = (ks >= 0 && k >= ks) ? va : ref_mem[a];
                    exp_rd[T+1+k*S] = 1'b1;
                    nrd = k + 1; rdat = v;
                    if (((v ^ d) & m) == '0) begin
                        err = 1'b0;
                        break;
                    end
                    err = 1'b1;
                end
                R = T + 1 + (nrd - 1) * S + 1 + L;
                if (ks >= 1) sw = T + 1 + ks * S - 2;
`else
                err = 1'b1; rdat = '0; R = T + 1;
`endif
            end
        endcase
        for (int c = T + 1; c <= R + stall; c++) begin
            exp_cr[c] = 1'b0;
            if (op != OP_POLL || R > T + 1) begin
                exp_av[c] = 1'b1; exp_addr[c] = a;
            end
        end
        for (int c = R; c <= R + stall; c++) begin
            exp_rv[c] = 1'b1; exp_rdat[c] = rdat; exp_err[c] = err;
        end
        do begin
            @(posedge clk); #1;
            bus.cmd_valid_i = 1'b0;
            bench_we = (cyc == sw);
            if (cyc >= R + stall) bus.rsp_ready_i = 1'b1;
        end while (cyc < R + stall);
        bench_we = 1'b0;
        if (ks >= 1) ref_mem[a] = va;
        t_acc = T;
        @(negedge clk); #1;
    endtask

    initial begin
        int t, rd0, wr0;
        for (int i = 0; i < NC; i++) exp_cr[i] = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        bus.cmd_valid_i = 1'b0; bus.cmd_op_i = '0; bus.cmd_addr_i = '0;
        bus.cmd_data_i = '0; bus.cmd_mask_i = '0; bus.rsp_ready_i = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", bus.cmd_ready_o, 1);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_rd_en", bus.reg_rd_en_o, 0);
        check("rst_wr_en", bus.reg_wr_en_o, 0);
        check("rst_addr", bus.reg_addr_o, 0);
        check("rst_wr_data", bus.reg_wr_data_o, 0);
        check("rst_rsp_data", bus.rsp_data_o, 0);
        check("rst_rsp_err", bus.rsp_err_o, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        poke(8'h01, 32'hA5A5_0000);
        rd0 = rd_seen;
        issue(OP_RD, 8'h01, '0, '0, 0, -1, '0, t);
        check("read_latency", rsp_first - t, 3);
        check("read_data", last_data, 32'hA5A5_0000);
        check("read_err", last_err, 0);
        check("read_strobes", rd_seen - rd0, 1);

        issue(OP_WR, 8'h00, 32'h0002_8003, '0, 0, -1, '0, t);
        check("write_latency", rsp_first - t, 2);
        check("write_mem", mem[0], 32'h0002_8003);

        poke(8'h01, 32'hC000_0015);
        rd0 = rd_seen; wr0 = wr_seen;
        issue(OP_RMW, 8'h01, 32'h0000_0155, 32'h0000_07FF, 0, -1, '0, t);
        check("rmw_data", last_data, 32'hC000_0155);
        check("rmw_mem", mem[1], 32'hC000_0155);
        check("rmw_rd_strobes", rd_seen - rd0, 1);
        check("rmw_wr_strobes", wr_seen - wr0, 1);
        check("rmw_latency", rsp_first - t, 4);

        issue(OP_RD, 8'h00, '0, '0, 5, -1, '0, t);
        check("stall_data", last_data, 32'h0002_8003);

        issue(OP_WR, 8'h10, 32'hDEAD_BEEF, '0, 0, -1, '0, t);
        issue(OP_RD, 8'h10, '0, '0, 0, -1, '0, t);
        check("b2b_data", last_data, 32'hDEAD_BEEF);

`ifdef CSR_BUS_MASTER_POLL_EN
        poke(8'h02, 32'h0000_0000);
        rd0 = rd_seen;
        issue(OP_POLL, 8'h02, 32'h1, 32'h1, 0, -1, '0, t);
        check("poll_exh_strobes", rd_seen - rd0, 3);
        check("poll_exh_err", last_err, 1);
        check("poll_exh_latency", rsp_first - t, 11);

        poke(8'h03, 32'h0000_0000);
        rd0 = rd_seen;
        issue(OP_POLL, 8'h03, 32'h1, 32'h1, 0, 1, 32'h1, t);
        check("poll_hit_strobes", rd_seen - rd0, 2);
        check("poll_hit_err", last_err, 0);
        check("poll_hit_data", last_data, 32'h1);
`else
        rd0 = rd_seen;
        issue(OP_POLL, 8'h05, 32'h1, 32'h1, 0, -1, '0, t);
        check("poll_off_err", last_err, 1);
        check("poll_off_data", last_data, 0);
        check("poll_off_latency", rsp_first - t, 1);
        check("poll_off_strobes", rd_seen - rd0, 0);
`endif

        // Reset while an RMW waits for its read data.
        @(posedge clk); #1;
        t = cyc;
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = OP_RMW; bus.cmd_addr_i = 8'h01;
        bus.cmd_data_i = 32'hFFFF_FFFF; bus.cmd_mask_i = 32'hFFFF_FFFF;
        exp_rd[t+1] = 1'b1; exp_cr[t+1] = 1'b0;
        exp_av[t+1] = 1'b1; exp_addr[t+1] = 8'h01;
        wr0 = wr_seen;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rd_en", bus.reg_rd_en_o, 0);
        check("rst_mid_wr_en", bus.reg_wr_en_o, 0);
        check("rst_mid_cmd_ready", bus.cmd_ready_o, 1);
        check("rst_mid_rsp_valid", bus.rsp_valid_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_write", wr_seen - wr0, 0);
        check("rst_mem_kept", mem[1], 32'hC000_0155);

        issue(OP_RD, 8'h01, '0, '0, 0, -1, '0, t);
        check("post_rst_read", last_data, 32'hC000_0155);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
